maze_dfs_engine: RTL and testbench

//  Parametrised depth-first maze solver: owns FSM, neighbour generation, path stack and result replay.

---
 rtl/maze_dfs_engine.sv | 235 +++++++++++++++++++++++
 tb/tb_maze_dfs_engine.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_dfs_engine.sv
// Depth-first maze solver over an external 1-bit cell memory.
// Keeps the path on an internal stack and replays it dst-first on a valid/ready port.
module maze_dfs_engine #(
    parameter int COORD_W     = 4,
    parameter int STACK_DEPTH = 256,
    localparam int ADDR_W     = 2 * COORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_loc,
    input  logic [ADDR_W-1:0] dst_loc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wdata,
    input  logic              mem_ack,
    input  logic              mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic              path_valid,
    input  logic              path_ready,
    output logic [ADDR_W-1:0] path_loc,
    output logic              path_last,
    output logic [ADDR_W:0]   step_cnt
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [SP_W-1:0]    SP_ONE   = SP_W'(1);
    localparam logic [SP_W-1:0]    SP_FULL  = SP_W'(STACK_DEPTH);
    localparam logic [ADDR_W:0]    STEP_ONE = (ADDR_W + 1)'(1);
    localparam logic [COORD_W-1:0] C_ONE    = COORD_W'(1);
    localparam logic [COORD_W-1:0] C_MAX    = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_PROBE,
        S_READ,
        S_BACK,
        S_FAIL,
        S_DONE,
        S_REPLAY
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] loc;
        logic [1:0]        dir;
    } entry_t;

    state_t            state;
    entry_t            stack_mem [STACK_DEPTH];
    entry_t            top;
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   sp_m1;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  top_idx;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] nxt;
    logic [2:0]        dir;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic              oob;
    logic              acked;
    logic              push;

    assign row      = cur[ADDR_W-1:COORD_W];
    assign col      = cur[COORD_W-1:0];
    assign sp_m1    = sp - SP_ONE;
    assign push_idx = sp[IDX_W-1:0];
    assign top_idx  = sp_m1[IDX_W-1:0];
    assign top      = stack_mem[top_idx];
    assign acked    = mem_req & mem_ack;
    assign push     = (state == S_READ) & acked & ~mem_rdata & (sp != SP_FULL);

    // Edges of the grid are hard walls: no wrap-around neighbours.
    always_comb begin
        nxt = cur;
        oob = 1'b1;
        case (dir)
            3'd0: begin
                oob = (row == '0);
                nxt = {row - C_ONE, col};
            end
            3'd1: begin
                oob = (col == C_MAX);
                nxt = {row, col + C_ONE};
            end
            3'd2: begin
                oob = (row == C_MAX);
                nxt = {row + C_ONE, col};
            end
            3'd3: begin
                oob = (col == '0);
                nxt = {row, col - C_ONE};
            end
            default: begin
                nxt = cur;
                oob = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[push_idx] <= '{loc: cur, dir: dir[1:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            sp         <= '0;
            cur        <= '0;
            dst        <= '0;
            dir        <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            path_valid <= 1'b0;
            path_loc   <= '0;
            path_last  <= 1'b0;
            step_cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        cur      <= src_loc;
                        dst      <= dst_loc;
                        dir      <= '0;
                        sp       <= '0;
                        step_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= S_MARK;
                    end
                end
                S_MARK: begin
                    if (!mem_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_wdata <= 1'b1;
                        mem_addr  <= cur;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (cur == dst) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            dir   <= '0;
                            state <= S_PROBE;
                        end
                    end
                end
                S_PROBE: begin
                    if (dir == 3'd4) begin
                        state <= S_BACK;
                    end else if (oob) begin
                        dir <= dir + 3'd1;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= nxt;
                        state    <= S_READ;
                    end
                end
                S_READ: begin
                    if (acked) begin
                        mem_req <= 1'b0;
                        if (mem_rdata) begin
                            dir   <= dir + 3'd1;
                            state <= S_PROBE;
                        end else if (sp == SP_FULL) begin
                            fail  <= 1'b1;
                            state <= S_FAIL;
                        end else begin
                            sp       <= sp + SP_ONE;
                            step_cnt <= step_cnt + STEP_ONE;
                            cur      <= mem_addr;
                            state    <= S_MARK;
                        end
                    end
                end
                S_BACK: begin
                    if (sp == '0) begin
                        fail  <= 1'b1;
                        state <= S_FAIL;
                    end else begin
                        cur      <= top.loc;
                        dir      <= {1'b0, top.dir} + 3'd1;
                        sp       <= sp_m1;
                        step_cnt <= step_cnt - STEP_ONE;
                        state    <= S_PROBE;
                    end
                end
                S_FAIL: begin
                    fail  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_DONE: begin
                    done       <= 1'b0;
                    path_valid <= 1'b1;
                    path_loc   <= cur;
                    path_last  <= (sp == '0);
                    state      <= S_REPLAY;
                end
                S_REPLAY: begin
                    // sp unwinds during replay; step_cnt keeps the path length.
                    if (path_ready) begin
                        if (path_last) begin
                            path_valid <= 1'b0;
                            path_last  <= 1'b0;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            path_loc  <= top.loc;
                            path_last <= (sp == SP_ONE);
                            sp        <= sp_m1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_dfs_engine.sv
// Directed bench for maze_dfs_engine on a 4x4 grid with a scoreboard
// for memory accesses and replay beats.
module tb_maze_dfs_engine;

    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start0, start1;
    logic [AW-1:0] src_loc, dst_loc;
    logic          mem_ack, mem_rdata, path_ready;

    logic          req0, we0, wd0, busy0, done0, fail0, pv0, plast0;
    logic [AW-1:0] addr0, ploc0;
    logic [AW:0]   step0;
    logic          req1, we1, wd1, busy1, done1, fail1, pv1, plast1;
    logic [AW-1:0] addr1, ploc1;
    logic [AW:0]   step1;

    maze_dfs_engine #(.COORD_W(2), .STACK_DEPTH(256)) dut (
        .clk(clk), .rst(rst), .start(start0),
        .src_loc(src_loc), .dst_loc(dst_loc),
        .mem_req(req0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy0), .done(done0), .fail(fail0),
        .path_valid(pv0), .path_ready(path_ready), .path_loc(ploc0),
        .path_last(plast0), .step_cnt(step0)
    );

    maze_dfs_engine #(.COORD_W(2), .STACK_DEPTH(2)) dut_small (
        .clk(clk), .rst(rst), .start(start1),
        .src_loc(src_loc), .dst_loc(dst_loc),
        .mem_req(req1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy1), .done(done1), .fail(fail1),
        .path_valid(pv1), .path_ready(path_ready), .path_loc(ploc1),
        .path_last(plast1), .step_cnt(step1)
    );

    logic          sel;
    logic          m_req, m_we, m_wd, m_busy, m_done, m_fail, m_pv, m_last;
    logic [AW-1:0] m_addr, m_loc;
    logic [AW:0]   m_step;

    assign m_req  = sel ? req1   : req0;
    assign m_we   = sel ? we1    : we0;
    assign m_wd   = sel ? wd1    : wd0;
    assign m_addr = sel ? addr1  : addr0;
    assign m_busy = sel ? busy1  : busy0;
    assign m_done = sel ? done1  : done0;
    assign m_fail = sel ? fail1  : fail0;
    assign m_pv   = sel ? pv1    : pv0;
    assign m_last = sel ? plast1 : plast0;
    assign m_loc  = sel ? ploc1  : ploc0;
    assign m_step = sel ? step1  : step0;

    // Cell memory with programmable ack latency; the idle engine ignores ack.
    logic [15:0] mem;
    logic [15:0] init_val;
    logic        init_go;
    int          lat;
    int          cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ack   <= 1'b0;
            mem_rdata <= 1'b0;
            cnt       <= 0;
        end else begin
            mem_ack <= 1'b0;
            if (init_go) begin
                mem <= init_val;
            end else if (m_req && !mem_ack) begin
                if (cnt >= lat) begin
                    mem_ack   <= 1'b1;
                    mem_rdata <= mem[m_addr];
                    if (m_we) mem[m_addr] <= m_wd;
                    cnt <= 0;
                end else begin
                    cnt <= cnt + 1;
                end
            end
        end
    end

    int errors = 0;
    int checks = 0;

    logic [4:0] exp_acc[$];
    logic [4:0] exp_beat[$];

    bit          chk_trace, rdy_toggle;
    int          wr_cnt, rd_cnt, done_cnt, fail_cnt, pv_cnt;
    logic [AW-1:0] last_wr;

    logic          p_req, p_ack, p_we, p_pv, p_rdy, p_last;
    logic [AW-1:0] p_addr, p_loc;

    localparam logic [4:0] S1_ACC [15] = '{
        5'h10, 5'h01, 5'h11, 5'h02, 5'h12, 5'h03, 5'h13, 5'h07,
        5'h17, 5'h03, 5'h0B, 5'h1B, 5'h07, 5'h0F, 5'h1F
    };
    localparam logic [4:0] S1_BEAT [7] = '{
        5'h0F, 5'h0B, 5'h07, 5'h03, 5'h02, 5'h01, 5'h10
    };
    localparam logic [4:0] S4_ACC [6] = '{
        5'h10, 5'h01, 5'h11, 5'h02, 5'h12, 5'h03
    };

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic       r;
        logic [4:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_req = 1'b0;
                p_ack = 1'b0;
                p_pv  = 1'b0;
                p_rdy = 1'b0;
            end else begin
                if (p_req && !p_ack) begin
                    chk("mem_hold_req", 32'(m_req), 32'd1);
                    chk("mem_hold_addr", 32'(m_addr), 32'(p_addr));
                    chk("mem_hold_we", 32'(m_we), 32'(p_we));
                end
                if (p_ack) chk("mem_req_drop", 32'(m_req), 32'd0);
                if (mem_ack) begin
                    if (m_we) begin
                        wr_cnt++;
                        last_wr = m_addr;
                    end else begin
                        rd_cnt++;
                    end
                    if (chk_trace) begin
                        e = (exp_acc.size() != 0) ? exp_acc.pop_front() : 5'h00;
                        chk("mem_access", 32'({m_we, m_addr}),
                            (exp_acc.size() == 0 && e == 5'h00) ? 32'hBAD : 32'(e));
                    end
                end
                if (m_done) done_cnt++;
                if (m_fail) fail_cnt++;
                if (p_pv && !p_rdy) begin
                    chk("beat_hold_valid", 32'(m_pv), 32'd1);
                    chk("beat_hold_loc", 32'(m_loc), 32'(p_loc));
                    chk("beat_hold_last", 32'(m_last), 32'(p_last));
                end
                r = rdy_toggle ? ~path_ready : 1'b1;
                path_ready = r;
                if (m_pv) pv_cnt++;
                if (m_pv && r) begin
                    if (exp_beat.size() == 0) begin
                        chk("beat_extra", 32'({m_last, m_loc}), 32'hBAD);
                    end else begin
                        e = exp_beat.pop_front();
                        chk("beat_loc", 32'(m_loc), 32'(e[3:0]));
                        chk("beat_last", 32'(m_last), 32'(e[4]));
                    end
                end
                p_req  = m_req;
                p_ack  = mem_ack;
                p_we   = m_we;
                p_addr = m_addr;
                p_pv   = m_pv;
                p_rdy  = r;
                p_loc  = m_loc;
                p_last = m_last;
            end
        end
    endtask

    task automatic push_s1();
        foreach (S1_ACC[i]) exp_acc.push_back(S1_ACC[i]);
        foreach (S1_BEAT[i]) exp_beat.push_back(S1_BEAT[i]);
    endtask

    task automatic run(input logic inst, input logic [AW-1:0] s,
                       input logic [AW-1:0] d, input int l, input bit tog,
                       input logic [15:0] preload, input bit go_wait);
        int n;
        sel        = inst;
        lat        = l;
        rdy_toggle = tog;
        wr_cnt     = 0;
        rd_cnt     = 0;
        done_cnt   = 0;
        fail_cnt   = 0;
        pv_cnt     = 0;
        last_wr    = '0;
        init_val   = preload;
        init_go    = 1'b1;
        @(negedge clk);
        init_go = 1'b0;
        src_loc = s;
        dst_loc = d;
        if (inst) start1 = 1'b1;
        else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        if (go_wait) begin
            for (n = 0; n < 3000; n++) begin
                @(negedge clk);
                if (!m_busy) break;
            end
            chk("finish_in_time", 32'(n < 3000), 32'd1);
            @(negedge clk);
        end
    endtask

    task automatic check_s1(input string tag);
        chk({tag, "_done"}, 32'(done_cnt), 32'd1);
        chk({tag, "_fail"}, 32'(fail_cnt), 32'd0);
        chk({tag, "_step"}, 32'(m_step), 32'd6);
        chk({tag, "_writes"}, 32'(wr_cnt), 32'd7);
        chk({tag, "_acc_left"}, 32'(exp_acc.size()), 32'd0);
        chk({tag, "_beat_left"}, 32'(exp_beat.size()), 32'd0);
        chk({tag, "_busy"}, 32'(m_busy), 32'd0);
    endtask

    initial begin
        start0 = 1'b0; start1 = 1'b0;
        src_loc = '0; dst_loc = '0;
        path_ready = 1'b0;
        init_go = 1'b0; init_val = '0;
        lat = 0; sel = 1'b0;
        rdy_toggle = 1'b0; chk_trace = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_req", 32'(req0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_fail", 32'(fail0), 32'd0);
        chk("rst_valid", 32'(pv0), 32'd0);
        chk("rst_step", 32'(step0), 32'd0);
        chk("rst_addr", 32'(addr0), 32'd0);
        chk("rst_small_busy", 32'(busy1), 32'd0);
        rst = 1'b0;
        fork
            monitor();
        join_none

        // Open grid, immediate ack.
        chk_trace = 1'b1;
        push_s1();
        run(1'b0, 4'h0, 4'hF, 0, 1'b0, 16'h0000, 1'b1);
        check_s1("s1");

        // Source equals destination.
        exp_acc.push_back(5'h15);
        exp_beat.push_back(5'h15);
        run(1'b0, 4'h5, 4'h5, 0, 1'b0, 16'h0000, 1'b1);
        chk("s2_done", 32'(done_cnt), 32'd1);
        chk("s2_reads", 32'(rd_cnt), 32'd0);
        chk("s2_writes", 32'(wr_cnt), 32'd1);
        chk("s2_step", 32'(step0), 32'd0);
        chk("s2_beat_left", 32'(exp_beat.size()), 32'd0);

        // Destination walled off by 0xB and 0xE.
        chk_trace = 1'b0;
        run(1'b0, 4'h0, 4'hF, 0, 1'b0, 16'h4800, 1'b1);
        chk("s3_writes", 32'(wr_cnt), 32'd13);
        chk("s3_fail", 32'(fail_cnt), 32'd1);
        chk("s3_done", 32'(done_cnt), 32'd0);
        chk("s3_step", 32'(step0), 32'd0);
        chk("s3_valid", 32'(pv_cnt), 32'd0);

        // Two-entry stack overflows on the third push.
        chk_trace = 1'b1;
        foreach (S4_ACC[i]) exp_acc.push_back(S4_ACC[i]);
        run(1'b1, 4'h0, 4'hF, 0, 1'b0, 16'h0000, 1'b1);
        chk("s4_fail", 32'(fail_cnt), 32'd1);
        chk("s4_done", 32'(done_cnt), 32'd0);
        chk("s4_last_wr", 32'(last_wr), 32'h2);
        chk("s4_step", 32'(step1), 32'd2);
        chk("s4_acc_left", 32'(exp_acc.size()), 32'd0);

        // Slow memory and a stuttering consumer.
        push_s1();
        run(1'b0, 4'h0, 4'hF, 3, 1'b1, 16'h0000, 1'b1);
        check_s1("s5");

        // Reset in the middle of a search, then a clean rerun.
        push_s1();
        run(1'b0, 4'h0, 4'hF, 0, 1'b0, 16'h0000, 1'b0);
        repeat (12) @(negedge clk);
        chk("s6_busy_before", 32'(busy0), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("s6_rst_req", 32'(req0), 32'd0);
        chk("s6_rst_busy", 32'(busy0), 32'd0);
        chk("s6_rst_step", 32'(step0), 32'd0);
        chk("s6_rst_addr", 32'(addr0), 32'd0);
        chk("s6_rst_we", 32'(we0), 32'd0);
        chk("s6_rst_valid", 32'(pv0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_acc.delete();
        exp_beat.delete();
        push_s1();
        run(1'b0, 4'h0, 4'hF, 0, 1'b0, 16'h0000, 1'b1);
        check_s1("s6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
